// File: rtl/agusec_bounds_pipe.sv
// Two-stage bounds checker for compressed-capability accesses: S1 forms the start/end
// addresses, S2 checks both against the capability window and keeps the fault counter/capture.
module agusec_bounds_pipe #(
   parameter int AW   = 64,
   parameter int MW   = 7,
   parameter int EW   = 5,
   parameter int GS   = 4,
   parameter int TW   = 6,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic [AW-1:0]   in_base,
   input  logic [AW-1:0]   in_off,
   input  logic [2:0]      in_size_l2,
   input  logic [EW-1:0]   in_exp,
   input  logic [MW-1:0]   in_low,
   input  logic [MW-1:0]   in_hi,
   input  logic            in_on_low,
   input  logic [TW-1:0]   in_tag,
   input  logic            flush,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [AW-1:0]   out_addr,
   output logic [TW-1:0]   out_tag,
   output logic            out_ok,
   output logic [1:0]      out_code,
   output logic            flt_vld,
   output logic [AW-1:0]   flt_addr,
   output logic [TW-1:0]   flt_tag,
   output logic [1:0]      flt_code,
   input  logic            flt_clr,
   output logic [CNTW-1:0] flt_cnt
);

   // Window test; address bits shifted in from above AW read as zero.
   function automatic logic win_pass(input logic [AW-1:0] a, input logic [EW-1:0] e,
                                     input logic [MW-1:0] lo, input logic [MW-1:0] hi,
                                     input logic onl);
      logic [AW-1:0] sh;
      logic [MW:0]   w;
      logic [MW:0]   bl;
      logic [MW:0]   bh;
      logic          r;
      logic          p;
      sh = a >> (int'(e) + GS);
      w  = sh[MW:0];
      r  = sh[MW+1];
      bl = {lo, 1'b0};
      bh = {hi, 1'b1};
      if (&e)
         p = 1'b1;
      else if (hi >= lo)
         p = (r == onl) && (w >= bl) && (w <= bh);
      else if (r == onl)
         p = (w >= bl);
      else
         p = (w <= bh);
      return p;
   endfunction

   logic            s1_vld;
   logic [AW-1:0]   s1_addr;
   logic [AW-1:0]   s1_end;
   logic            s1_ovf;
   logic [EW-1:0]   s1_exp;
   logic [MW-1:0]   s1_low;
   logic [MW-1:0]   s1_hi;
   logic            s1_on_low;
   logic [TW-1:0]   s1_tag;

   logic            s1_adv;
   logic            acc;
   logic            flt_hs;
   logic [AW:0]     sum0;
   logic [AW:0]     sum1;
   logic [AW-1:0]   inc;
   logic            ps;
   logic            pe;
   logic [1:0]      s2_code;

   assign s1_adv = ~out_vld | out_rdy;
   assign in_rdy = ~flush & (~s1_vld | s1_adv);
   assign acc    = in_vld & in_rdy;
   assign flt_hs = out_vld & out_rdy & ~out_ok;

   always_comb begin
      inc  = (AW'(1) << in_size_l2) - AW'(1);
      sum0 = {1'b0, in_base} + {1'b0, in_off};
      sum1 = {1'b0, sum0[AW-1:0]} + {1'b0, inc};
   end

   always_comb begin
      ps = win_pass(s1_addr, s1_exp, s1_low, s1_hi, s1_on_low);
      pe = win_pass(s1_end,  s1_exp, s1_low, s1_hi, s1_on_low);
      // Overflow outranks everything, including the max-exponent bypass.
      if (s1_ovf)   s2_code = 2'b11;
      else if (!ps) s2_code = 2'b01;
      else if (!pe) s2_code = 2'b10;
      else          s2_code = 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_addr   <= '0;
         s1_end    <= '0;
         s1_ovf    <= 1'b0;
         s1_exp    <= '0;
         s1_low    <= '0;
         s1_hi     <= '0;
         s1_on_low <= 1'b0;
         s1_tag    <= '0;
      end else begin
         if (flush)       s1_vld <= 1'b0;
         else if (acc)    s1_vld <= 1'b1;
         else if (s1_adv) s1_vld <= 1'b0;
         if (acc) begin
            s1_addr   <= sum0[AW-1:0];
            s1_end    <= sum1[AW-1:0];
            s1_ovf    <= sum0[AW] | sum1[AW];
            s1_exp    <= in_exp;
            s1_low    <= in_low;
            s1_hi     <= in_hi;
            s1_on_low <= in_on_low;
            s1_tag    <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_addr <= '0;
         out_tag  <= '0;
         out_ok   <= 1'b0;
         out_code <= '0;
      end else begin
         if (flush)       out_vld <= 1'b0;
         else if (s1_adv) out_vld <= s1_vld;
         if (!flush && s1_adv && s1_vld) begin
            out_addr <= s1_addr;
            out_tag  <= s1_tag;
            out_ok   <= (s2_code == 2'b00);
            out_code <= s2_code;
         end
      end
   end

   // A clear coinciding with a faulting handshake leaves exactly that fault recorded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flt_vld  <= 1'b0;
         flt_addr <= '0;
         flt_tag  <= '0;
         flt_code <= '0;
         flt_cnt  <= '0;
      end else if (flt_clr) begin
         flt_vld  <= flt_hs;
         flt_addr <= flt_hs ? out_addr : '0;
         flt_tag  <= flt_hs ? out_tag  : '0;
         flt_code <= flt_hs ? out_code : 2'b00;
         flt_cnt  <= flt_hs ? CNTW'(1) : '0;
      end else if (flt_hs) begin
         if (!(&flt_cnt)) flt_cnt <= flt_cnt + CNTW'(1);
         if (!flt_vld) begin
            flt_vld  <= 1'b1;
            flt_addr <= out_addr;
            flt_tag  <= out_tag;
            flt_code <= out_code;
         end
      end
   end

endmodule

// File: tb/tb_agusec_bounds_pipe.sv
// Bench for agusec_bounds_pipe: directed scenarios plus random traffic scored against an
// arithmetic reference model of the window rules and a slot-count model of the pipeline.
module tb_agusec_bounds_pipe;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_vld, in_rdy;
   logic [63:0]   in_base, in_off;
   logic [2:0]    in_size_l2;
   logic [4:0]    in_exp;
   logic [6:0]    in_low, in_hi;
   logic          in_on_low;
   logic [5:0]    in_tag;
   logic          flush;
   logic          out_vld, out_rdy;
   logic [63:0]   out_addr;
   logic [5:0]    out_tag;
   logic          out_ok;
   logic [1:0]    out_code;
   logic          flt_vld;
   logic [63:0]   flt_addr;
   logic [5:0]    flt_tag;
   logic [1:0]    flt_code;
   logic          flt_clr;
   logic [15:0]   flt_cnt;

   logic          in_rdy2, out_vld2, out_ok2, flt_vld2;
   logic [63:0]   out_addr2, flt_addr2;
   logic [5:0]    out_tag2, flt_tag2;
   logic [1:0]    out_code2, flt_code2;
   logic [1:0]    flt_cnt2;

   agusec_bounds_pipe dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_base(in_base),
      .in_off(in_off), .in_size_l2(in_size_l2), .in_exp(in_exp), .in_low(in_low),
      .in_hi(in_hi), .in_on_low(in_on_low), .in_tag(in_tag), .flush(flush),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_tag(out_tag),
      .out_ok(out_ok), .out_code(out_code), .flt_vld(flt_vld), .flt_addr(flt_addr),
      .flt_tag(flt_tag), .flt_code(flt_code), .flt_clr(flt_clr), .flt_cnt(flt_cnt)
   );

   agusec_bounds_pipe #(.CNTW(2)) dut2 (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy2), .in_base(in_base),
      .in_off(in_off), .in_size_l2(in_size_l2), .in_exp(in_exp), .in_low(in_low),
      .in_hi(in_hi), .in_on_low(in_on_low), .in_tag(in_tag), .flush(flush),
      .out_vld(out_vld2), .out_rdy(out_rdy), .out_addr(out_addr2), .out_tag(out_tag2),
      .out_ok(out_ok2), .out_code(out_code2), .flt_vld(flt_vld2), .flt_addr(flt_addr2),
      .flt_tag(flt_tag2), .flt_code(flt_code2), .flt_clr(flt_clr), .flt_cnt(flt_cnt2)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
      n_chk++;
      if (act !== exp_v)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
      else
         n_pass++;
   endtask

   function automatic bit ref_pass(input logic [63:0] a, input int e, input int lo,
                                   input int hi, input int onl);
      logic [127:0] aa;
      int s, w, r, bl, bh;
      if (e == 31) return 1'b1;
      s  = e + 4;
      aa = {64'd0, a};
      w  = int'((aa >> s) % 256);
      r  = int'((aa >> (s + 8)) % 2);
      bl = lo * 2;
      bh = hi * 2 + 1;
      if (hi >= lo) return (r == onl) && (w >= bl) && (w <= bh);
      if (r == onl) return w >= bl;
      return w <= bh;
   endfunction

   function automatic logic [1:0] ref_code(input logic [63:0] b, input logic [63:0] o,
                                           input int sz, input int e, input int lo,
                                           input int hi, input int onl);
      logic [127:0] sum, endv;
      sum  = {64'd0, b} + {64'd0, o};
      endv = {64'd0, sum[63:0]} + (128'd1 << sz) - 128'd1;
      if (sum[64] || endv[64]) return 2'b11;
      if (!ref_pass(sum[63:0], e, lo, hi, onl)) return 2'b01;
      if (!ref_pass(endv[63:0], e, lo, hi, onl)) return 2'b10;
      return 2'b00;
   endfunction

   typedef struct {
      logic [63:0] addr;
      logic [5:0]  tag;
      logic [1:0]  code;
      int          age;
   } exp_t;

   exp_t        q[$];
   exp_t        m_e;
   int          m_cnt;
   bit          m_fv;
   logic [63:0] m_faddr;
   logic [5:0]  m_ftag;
   logic [1:0]  m_fcode;
   bit          m_er, m_eo, m_hs, m_acc;

   // Pipeline model: at most two requests in flight, each visible at the output two edges after accept.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         m_cnt = 0;
         m_fv  = 1'b0;
      end else begin
         m_er = !flush && (q.size() < 2 || out_rdy);
         m_eo = q.size() > 0 && q[0].age >= 2;
         chk("in_rdy", 64'(in_rdy), 64'(m_er));
         chk("out_vld", 64'(out_vld), 64'(m_eo));
         if (m_eo) begin
            chk("out_addr", out_addr, q[0].addr);
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            chk("out_code", 64'(out_code), 64'(q[0].code));
            chk("out_ok", 64'(out_ok), 64'(q[0].code == 2'b00));
         end
         chk("flt_cnt", 64'(flt_cnt), 64'(m_cnt));
         chk("flt_cnt_sat", 64'(flt_cnt2), 64'(m_cnt > 3 ? 3 : m_cnt));
         chk("flt_vld", 64'(flt_vld), 64'(m_fv));
         if (m_fv) begin
            chk("flt_addr", flt_addr, m_faddr);
            chk("flt_tag", 64'(flt_tag), 64'(m_ftag));
            chk("flt_code", 64'(flt_code), 64'(m_fcode));
         end
         m_hs  = m_eo && out_rdy;
         m_acc = in_vld && m_er;
         if (flt_clr) begin
            m_cnt = 0;
            m_fv  = 1'b0;
         end
         if (m_hs && q[0].code != 2'b00) begin
            m_cnt++;
            if (!m_fv) begin
               m_fv    = 1'b1;
               m_faddr = q[0].addr;
               m_ftag  = q[0].tag;
               m_fcode = q[0].code;
            end
         end
         if (flush) q.delete();
         else begin
            if (m_hs) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (m_acc) begin
               m_e.addr = in_base + in_off;
               m_e.tag  = in_tag;
               m_e.code = ref_code(in_base, in_off, int'(in_size_l2), int'(in_exp),
                                   int'(in_low), int'(in_hi), int'(in_on_low));
               m_e.age  = 1;
               q.push_back(m_e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_win(input logic [4:0] e, input logic [6:0] lo, input logic [6:0] hi,
                          input logic onl);
      in_exp = e; in_low = lo; in_hi = hi; in_on_low = onl;
   endtask

   // One request through an idle pipe with out_rdy high; optional flt_clr on its output handshake.
   task automatic one_req(input logic [63:0] b, input logic [63:0] o, input logic [2:0] sz,
                          input logic [5:0] tg, input logic [1:0] ecode, input bit clr);
      in_base = b; in_off = o; in_size_l2 = sz; in_tag = tg;
      in_vld = 1'b1; out_rdy = 1'b1;
      #1 chk("acc_rdy", 64'(in_rdy), 64'd1);
      tick();
      in_vld = 1'b0;
      chk("lat1_vld", 64'(out_vld), 64'd0);
      tick();
      chk("lat2_vld", 64'(out_vld), 64'd1);
      chk("req_code", 64'(out_code), 64'(ecode));
      chk("req_addr", out_addr, b + o);
      chk("req_tag", 64'(out_tag), 64'(tg));
      flt_clr = clr;
      tick();
      flt_clr = 1'b0;
      chk("drain_vld", 64'(out_vld), 64'd0);
   endtask

   logic [5:0] got [3];

   initial begin
      rst = 1'b1; in_vld = 1'b0; in_base = '0; in_off = '0; in_size_l2 = '0;
      in_exp = '0; in_low = '0; in_hi = '0; in_on_low = 1'b0; in_tag = '0;
      flush = 1'b0; out_rdy = 1'b1; flt_clr = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #2;
      chk("rst_in_rdy", 64'(in_rdy), 64'd1);
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_flt_cnt", 64'(flt_cnt), 64'd0);
      chk("rst_flt_vld", 64'(flt_vld), 64'd0);
      tick();

      set_win(5'd0, 7'h10, 7'h20, 1'b0);
      one_req(64'h300, 64'h0, 3'd3, 6'd1, 2'b00, 1'b0);
      one_req(64'h1F0, 64'h0, 3'd0, 6'd2, 2'b01, 1'b0);
      one_req(64'h400, 64'h10, 3'd5, 6'd3, 2'b10, 1'b0);
      set_win(5'd0, 7'h70, 7'h08, 1'b0);
      one_req(64'hF00, 64'h0, 3'd0, 6'd4, 2'b00, 1'b0);
      one_req(64'h1050, 64'h0, 3'd0, 6'd5, 2'b00, 1'b0);
      one_req(64'h1F00, 64'h0, 3'd0, 6'd6, 2'b01, 1'b0);
      set_win(5'd31, 7'h70, 7'h08, 1'b0);
      one_req(64'h1F00, 64'h0, 3'd0, 6'd7, 2'b00, 1'b0);
      one_req(64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 3'd4, 6'd8, 2'b11, 1'b0);
      set_win(5'd0, 7'h10, 7'h20, 1'b0);
      one_req(64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 3'd4, 6'd9, 2'b11, 1'b0);

      // Backpressure: three back-to-back requests against a stalled output.
      out_rdy = 1'b0; in_size_l2 = 3'd0; in_off = '0;
      in_vld = 1'b1; in_base = 64'h300; in_tag = 6'd10;
      tick();
      in_base = 64'h310; in_tag = 6'd11;
      tick();
      in_base = 64'h320; in_tag = 6'd12;
      #1;
      chk("bp_rdy", 64'(in_rdy), 64'd0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_vld", 64'(out_vld), 64'd1);
         chk("bp_hold_tag", 64'(out_tag), 64'd10);
         chk("bp_hold_addr", out_addr, 64'h300);
         tick();
      end
      out_rdy = 1'b1;
      got[0] = out_tag;
      tick();
      in_vld = 1'b0;
      got[1] = out_tag;
      tick();
      got[2] = out_tag;
      chk("bp_order0", 64'(got[0]), 64'd10);
      chk("bp_order1", 64'(got[1]), 64'd11);
      chk("bp_order2", 64'(got[2]), 64'd12);
      tick();

      // Flush with two requests in flight.
      out_rdy = 1'b0; in_vld = 1'b1; in_tag = 6'd13;
      tick();
      in_tag = 6'd14;
      tick();
      in_vld = 1'b0; flush = 1'b1;
      #1 chk("flush_rdy", 64'(in_rdy), 64'd0);
      tick();
      flush = 1'b0; out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("flush_no_vld", 64'(out_vld), 64'd0);
         tick();
      end

      // Asynchronous reset with a result waiting at the output.
      out_rdy = 1'b0; in_vld = 1'b1; in_tag = 6'd15;
      tick();
      in_vld = 1'b0;
      tick();
      chk("pre_rst_vld", 64'(out_vld), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_vld", 64'(out_vld), 64'd0);
      chk("async_rst_cnt", 64'(flt_cnt), 64'd0);
      tick();
      rst = 1'b0; out_rdy = 1'b1;
      tick();

      // Fault bookkeeping.
      set_win(5'd0, 7'h10, 7'h20, 1'b0);
      one_req(64'h1F0, 64'h0, 3'd0, 6'd20, 2'b01, 1'b0);
      one_req(64'h1F8, 64'h0, 3'd0, 6'd21, 2'b01, 1'b0);
      chk("flt2_cnt", 64'(flt_cnt), 64'd2);
      chk("flt2_vld", 64'(flt_vld), 64'd1);
      chk("flt2_addr", flt_addr, 64'h1F0);
      chk("flt2_tag", 64'(flt_tag), 64'd20);
      one_req(64'h500, 64'h0, 3'd0, 6'd22, 2'b01, 1'b1);
      chk("clr_cnt", 64'(flt_cnt), 64'd1);
      chk("clr_vld", 64'(flt_vld), 64'd1);
      chk("clr_addr", flt_addr, 64'h500);
      chk("clr_tag", 64'(flt_tag), 64'd22);
      for (int i = 0; i < 4; i++)
         one_req(64'h1F0, 64'h0, 3'd0, 6'(30 + i), 2'b01, 1'b0);
      chk("cnt5", 64'(flt_cnt), 64'd5);
      chk("cnt_sat3", 64'(flt_cnt2), 64'd3);

      // Random traffic, scored by the monitor.
      for (int i = 0; i < 600; i++) begin
         in_vld  = ($urandom_range(0, 3) != 0);
         out_rdy = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 39) == 0);
         flt_clr = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 3))
            0, 1:    in_base = 64'($urandom_range(0, 'h3FFF));
            2:       in_base = {32'hFFFF_FFFF, 24'hFF_FFFF, 8'($urandom_range(0, 255))};
            default: in_base = {$urandom, $urandom};
         endcase
         in_off     = 64'($urandom_range(0, 'h200));
         in_size_l2 = 3'($urandom_range(0, 7));
         in_exp     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 2));
         in_low     = 7'($urandom_range(0, 127));
         in_hi      = 7'($urandom_range(0, 127));
         in_on_low  = 1'($urandom_range(0, 1));
         in_tag     = 6'($urandom_range(0, 63));
         tick();
      end
      in_vld = 1'b0; out_rdy = 1'b1; flush = 1'b0; flt_clr = 1'b0;
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/agusec_bounds_pipe.md
# agusec_bounds_pipe

Pipelined, parametrised bounds checker for compressed-capability memory accesses, the successor to the single-cycle AGU security range check. It adds base+offset, derives the last byte of a 1–128-byte access, and checks both start and end against the capability window. It reports a fault class, and keeps a saturating fault counter and a first-fault capture register. It sits between the AGU issue stage and the LSQ, with valid/ready flow control on both sides.

## Interface
Parameters:
- AW, 64, address width
- MW, 7, low/hi mantissa field width
- EW, 5, exponent width
- GS, 4, granule shift added to exponent
- TW, 6, tag width
- CNTW, 16, fault counter width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous and active-high
- in_vld  in  1  request valid
- in_rdy  out  1  request accepted when in_vld&in_rdy
- in_base, in_off  in  AW  base and offset
- in_size_l2  in  3  access size = 1<<in_size_l2 bytes
- in_exp  in  EW; in_low, in_hi  in  MW; in_on_low  in  1  capability bound fields
- in_tag  in  TW  opaque, returned with result
- flush  in  1  kill all in-flight requests
- out_vld  out  1; out_rdy  in  1  result handshake
- out_addr  out  AW  in_base+in_off
- out_tag  out  TW
- out_ok  out  1  access permitted
- out_code  out  2  00 ok, 01 start outside, 10 end outside (crossing), 11 address overflow
- flt_vld  out  1; flt_addr  out  AW; flt_tag  out  TW; flt_code  out  2  first-fault capture
- flt_clr  in  1  clears capture and counter
- flt_cnt  out  CNTW  saturating fault count

## Operation
- Window check of an address a:
  - s = exp+GS; w = a[s+MW:s] (MW+1 bits); r = a[s+MW+1]; bits at or above AW read as 0.
  - L = {low,1'b0}; H = {hi,1'b1}.
  - Non-wrapped (hi>=low): pass iff r==on_low && L<=w<=H.
  - Wrapped (hi<low): if r==on_low, pass iff w>=L; else pass iff w<=H.
  - exp all-ones: pass unconditionally.
- Stage 1, registered into S1:
  - addr = base+off (AW bits, carry c0).
  - end = addr + (1<<size_l2) - 1 (carry c1).
  - ovf = c0|c1.
- Stage 2, registered into S2:
  - ps = pass(addr); pe = pass(end).
  - code: 11 if ovf; else 01 if ~ps; else 10 if ~pe; else 00.
  - out_ok = (code==00).
  - Max exponent does not suppress 11.
- Flow control:
  - s1_adv = ~s2_vld | out_rdy.
  - in_rdy = ~flush & (~s1_vld | s1_adv).
  - S2 loads from S1 when s1_adv.
  - out_* are S2 registers; they are held stable while out_vld & ~out_rdy.
- Flush: s1_vld and s2_vld clear at the next edge; in_rdy=0 during flush, so nothing is accepted that cycle.
- Fault bookkeeping, on each out handshake with out_ok=0:
  - flt_cnt increments, saturating at all-ones.
  - If flt_vld=0, load flt_addr/tag/code and set flt_vld.
- flt_clr, including simultaneous with a faulting handshake:
  - Clear is applied first, then the new fault is counted and captured.
  - Result: flt_cnt=1, flt_vld=1 with the new fault.
- Reset: all valids, out_*, flt_* and flt_cnt = 0; in_rdy=1 once rst deasserts.

## Timing
- Latency: 2 cycles from accept to out_vld with out_rdy held high; throughput 1/cycle.
- Backpressure: out_rdy low holds S2. S1 fills one cycle later, then in_rdy drops. Maximum 2 requests in flight; no loss, no reorder.
- Simultaneous out handshake and new accept on a full pipe: both occur and the pipeline shifts.
- flt_cnt/flt_vld update the edge after the handshake.
- rst mid-operation discards in-flight requests immediately (asynchronous).

## Test plan
Default parameters unless stated; exp=0, so w=a[11:4] and r=a[12].
- Window low=0x10, hi=0x20, on_low=0:
  - base=0x300, off=0, size_l2=3 -> out_code=00 and out_addr=0x300 two cycles after accept.
  - base=0x1F0 -> code 01.
- Same window, base=0x400, off=0x10, size_l2=5 -> end 0x42F, w=0x42 > H=0x41 -> code 10.
- Wrapped window low=0x70, hi=0x08, on_low=0:
  - 0xF00 -> 00; 0x1050 -> 00; 0x1F00 -> 01.
  - exp=31 with any address -> 00.
- base=0xFFFF_FFFF_FFFF_FFF8, off=0, size_l2=4 -> code 11 regardless of exp.
- Three back-to-back requests with out_rdy low for 3 cycles:
  - in_rdy drops after 2 accepts; outputs remain stable.
  - All 3 results then emerge in order, tags intact.
- Fault bookkeeping and flush:
  - Two faults -> flt_cnt=2, capture holds the first.
  - flt_clr with a third fault -> flt_cnt=1, capture = third.
  - CNTW=2: five faults -> flt_cnt=3.
  - flush with 2 in flight -> no out_vld.
